pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 11 +
 rtl/pipeline_hazard_ctrl_hazard_cmp.sv | 17 +
 rtl/pipeline_hazard_ctrl.sv | 82 ++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared Hi/Lo FSM encoding and multiply latency default
package pipeline_hazard_ctrl_pkg;

    localparam int MUL_LATENCY_DEFAULT = 4;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// hazard_cmp: load-use register compare between EX load destination and ID sources
module hazard_cmp (
    input  logic       ex_mem_read_i,
    input  logic [4:0] ex_rd_i,
    input  logic [4:0] id_rs_i,
    input  logic [4:0] id_rt_i,
    input  logic       id_uses_rt_i,
    output logic       load_use_o
);

    // register 0 is hardwired, so a load targeting it never creates a dependency
    always_comb begin
        load_use_o = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                     ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: load-use and Hi/Lo interlock, branch flush and stall counter
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [4:0]       ID_Rs,
    input  logic [4:0]       ID_Rt,
    input  logic             ID_UsesRt,
    input  logic             ID_IsMulDiv,
    input  logic             ID_ReadsHiLo,
    input  logic             ID_BranchTaken,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WriteRegCarry,
    output logic             PC_Write,
    output logic             IF_ID_Write,
    output logic             IF_ID_Flush,
    output logic             ID_EX_Bubble,
    output logic             HiLo_Busy,
    output logic [CNT_W-1:0] StallCycles
);

    md_state_e        state_q, state_d;
    logic [3:0]       md_cnt_q, md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use, md_hazard, stall;

    hazard_cmp u_cmp (
        .ex_mem_read_i (EX_MemRead),
        .ex_rd_i       (EX_WriteRegCarry),
        .id_rs_i       (ID_Rs),
        .id_rt_i       (ID_Rt),
        .id_uses_rt_i  (ID_UsesRt),
        .load_use_o    (load_use)
    );

    // stall decode and Mealy pipeline controls; reset forces a frozen, flushing pipe
    always_comb begin
        md_hazard    = (state_q == MD_BUSY) && (ID_IsMulDiv || ID_ReadsHiLo);
        stall        = load_use || md_hazard;
        PC_Write     = Reset && !stall;
        IF_ID_Write  = Reset && !stall;
        IF_ID_Flush  = !Reset || (!stall && ID_BranchTaken);
        ID_EX_Bubble = !Reset || stall;
        HiLo_Busy    = Reset && (state_q == MD_BUSY);
    end

    // Hi/Lo occupancy FSM; a MulDiv issuing on the return-to-RUN cycle reloads at once
    always_comb begin
        state_d  = state_q;
        md_cnt_d = md_cnt_q;
        if (state_q == RUN) begin
            if (ID_IsMulDiv && !stall) begin
                state_d  = MD_BUSY;
                md_cnt_d = 4'(MUL_LATENCY - 1);
            end
        end else begin
            md_cnt_d = md_cnt_q - 4'd1;
            if (md_cnt_q == 4'd1) state_d = RUN;
        end
        stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    end

    // state, countdown and saturating stall counter registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= RUN;
            md_cnt_q    <= 4'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of stalls, flush priority, Hi/Lo interlock and counters
module tb_pipeline_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [4:0]  ID_Rs, ID_Rt, EX_WriteRegCarry;
    logic        ID_UsesRt, ID_IsMulDiv, ID_ReadsHiLo, ID_BranchTaken, EX_MemRead;
    logic        PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, HiLo_Busy;
    logic [15:0] StallCycles;
    logic        s_PC_Write, s_IF_ID_Write, s_IF_ID_Flush, s_ID_EX_Bubble, s_HiLo_Busy;
    logic [3:0]  s_StallCycles;
    int          tests = 0;
    int          fails = 0;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl dut (
        .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_IsMulDiv(ID_IsMulDiv), .ID_ReadsHiLo(ID_ReadsHiLo), .ID_BranchTaken(ID_BranchTaken),
        .EX_MemRead(EX_MemRead), .EX_WriteRegCarry(EX_WriteRegCarry),
        .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Bubble(ID_EX_Bubble), .HiLo_Busy(HiLo_Busy), .StallCycles(StallCycles)
    );

    pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
        .ID_IsMulDiv(ID_IsMulDiv), .ID_ReadsHiLo(ID_ReadsHiLo), .ID_BranchTaken(ID_BranchTaken),
        .EX_MemRead(EX_MemRead), .EX_WriteRegCarry(EX_WriteRegCarry),
        .PC_Write(s_PC_Write), .IF_ID_Write(s_IF_ID_Write), .IF_ID_Flush(s_IF_ID_Flush),
        .ID_EX_Bubble(s_ID_EX_Bubble), .HiLo_Busy(s_HiLo_Busy), .StallCycles(s_StallCycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ctl(input string tag, input logic pc, input logic ifw, input logic fl, input logic bb, input logic busy);
        check({tag, ".PC_Write"}, {31'd0, PC_Write}, {31'd0, pc});
        check({tag, ".IF_ID_Write"}, {31'd0, IF_ID_Write}, {31'd0, ifw});
        check({tag, ".IF_ID_Flush"}, {31'd0, IF_ID_Flush}, {31'd0, fl});
        check({tag, ".ID_EX_Bubble"}, {31'd0, ID_EX_Bubble}, {31'd0, bb});
        check({tag, ".HiLo_Busy"}, {31'd0, HiLo_Busy}, {31'd0, busy});
    endtask

    task automatic idle();
        ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0; ID_IsMulDiv = 1'b0; ID_ReadsHiLo = 1'b0;
        ID_BranchTaken = 1'b0; EX_MemRead = 1'b0; EX_WriteRegCarry = 5'd0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        Reset = 1'b0;
        idle();
        ID_BranchTaken = 1'b1;
        EX_MemRead = 1'b1; EX_WriteRegCarry = 5'd3; ID_Rs = 5'd3;
        settle();
        ctl("reset", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("reset.StallCycles", {16'd0, StallCycles}, 32'd0);
        tick(); tick();
        check("reset.StallCycles_held", {16'd0, StallCycles}, 32'd0);
        Reset = 1'b1;
        idle();
        settle();
        ctl("idle", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        EX_MemRead = 1'b1; EX_WriteRegCarry = 5'd8; ID_Rs = 5'd8;
        settle();
        ctl("loaduse_rs", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        check("loaduse_rs.count", {16'd0, StallCycles}, 32'd1);
        idle();
        EX_MemRead = 1'b1; EX_WriteRegCarry = 5'd9; ID_Rt = 5'd9; ID_Rs = 5'd4;
        settle();
        check("rt_unused.PC_Write", {31'd0, PC_Write}, 32'd1);
        ID_UsesRt = 1'b1;
        settle();
        check("rt_used.PC_Write", {31'd0, PC_Write}, 32'd0);
        tick();
        check("rt_used.count", {16'd0, StallCycles}, 32'd2);
        idle();
        EX_MemRead = 1'b1; EX_WriteRegCarry = 5'd0; ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b1;
        settle();
        ctl("zero_reg", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        EX_MemRead = 1'b0; EX_WriteRegCarry = 5'd8; ID_Rs = 5'd8;
        settle();
        check("no_load.PC_Write", {31'd0, PC_Write}, 32'd1);
        tick();
        check("no_load.count", {16'd0, StallCycles}, 32'd2);

        idle();
        EX_MemRead = 1'b1; EX_WriteRegCarry = 5'd12; ID_Rs = 5'd12; ID_BranchTaken = 1'b1;
        settle();
        ctl("branch_stalled", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        idle();
        ID_BranchTaken = 1'b1;
        settle();
        ctl("branch_after", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check("branch.count", {16'd0, StallCycles}, 32'd3);
        tick();

        idle();
        ID_IsMulDiv = 1'b1;
        settle();
        ctl("mult_c0", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        ID_ReadsHiLo = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            settle();
            ctl($sformatf("mfhi_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            tick();
        end
        settle();
        ctl("mfhi_c4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("mfhi.count", {16'd0, StallCycles}, 32'd6);
        tick();
        idle();
        settle();
        check("mfhi_after.count", {16'd0, StallCycles}, 32'd6);

        ID_IsMulDiv = 1'b1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            settle();
            ctl($sformatf("b2b_c%0d", c), 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            tick();
        end
        settle();
        ctl("b2b_c4", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        idle();
        settle();
        ctl("b2b_c5", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        check("b2b.count", {16'd0, StallCycles}, 32'd9);
        tick(); tick();
        settle();
        check("b2b_c7.HiLo_Busy", {31'd0, HiLo_Busy}, 32'd1);
        tick();
        settle();
        check("b2b_c8.HiLo_Busy", {31'd0, HiLo_Busy}, 32'd0);

        ID_IsMulDiv = 1'b1;
        tick();
        idle();
        tick();
        settle();
        check("rstmid_c2.HiLo_Busy", {31'd0, HiLo_Busy}, 32'd1);
        Reset = 1'b0;
        settle();
        ctl("rstmid_in", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("rstmid.count", {16'd0, StallCycles}, 32'd0);
        tick();
        Reset = 1'b1;
        ID_ReadsHiLo = 1'b1;
        settle();
        ctl("rstmid_release", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        check("rstmid_release.HiLo_Busy", {31'd0, HiLo_Busy}, 32'd0);

        idle();
        EX_MemRead = 1'b1; EX_WriteRegCarry = 5'd5; ID_Rs = 5'd5;
        for (int c = 0; c < 14; c++) tick();
        check("sat.at14", {28'd0, s_StallCycles}, 32'd14);
        for (int c = 0; c < 6; c++) tick();
        check("sat.held15", {28'd0, s_StallCycles}, 32'd15);
        check("sat.wide20", {16'd0, StallCycles}, 32'd20);
        idle();
        settle();
        check("sat.PC_Write", {31'd0, s_PC_Write}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
